inst_queue: RTL

Parametrised instruction buffer that sits between the fetch stage and the N-way decode stage. It replaces the fixed two-slot "instruction left over" handling in if_id.
- Fetch pushes up to FETCH_WIDTH instructions per cycle.
- Decode consumes 0..ISSUE_WIDTH instructions per cycle, in order.
- Each entry keeps its PC, fetch exception flag and delay-slot tag.
- Pipeline flush (exception or mispredict) empties the buffer.

---
 rtl/inst_queue.sv | 123 ++++++++++++
 1 files changed

// File: rtl/inst_queue.sv
// Circular instruction buffer between fetch and N-way decode; each entry carries PC, fetch-exception and delay-slot tags.
// Optional INST_QUEUE_BYPASS_EN: on an empty queue, pushed slots are presented to decode in the same cycle.
module inst_queue #(
    parameter int DEPTH       = 8,
    parameter int FETCH_WIDTH = 2,
    parameter int ISSUE_WIDTH = 2,
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                flush,
    input  logic [$clog2(FETCH_WIDTH+1)-1:0]    push_cnt,
    input  logic [FETCH_WIDTH*DATA_WIDTH-1:0]   push_inst,
    input  logic [ADDR_WIDTH-1:0]               push_pc,
    input  logic                                push_except,
    input  logic                                push_delayslot,
    output logic                                push_ready,
    output logic [ISSUE_WIDTH-1:0]              out_valid,
    output logic [ISSUE_WIDTH*DATA_WIDTH-1:0]   out_inst,
    output logic [ISSUE_WIDTH*ADDR_WIDTH-1:0]   out_pc,
    output logic [ISSUE_WIDTH-1:0]              out_except,
    output logic [ISSUE_WIDTH-1:0]              out_delayslot,
    input  logic [$clog2(ISSUE_WIDTH+1)-1:0]    pop_cnt,
    output logic [$clog2(DEPTH+1)-1:0]          count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [DATA_WIDTH-1:0] mem_inst [DEPTH];
    logic [ADDR_WIDTH-1:0] mem_pc   [DEPTH];
    logic                  mem_exc  [DEPTH];
    logic                  mem_ds   [DEPTH];

    logic [PTR_W-1:0] head, tail;
    logic [CNT_W-1:0] push_eff, push_n, pop_req, avail, pops, skip;
    logic             byp;

    assign push_ready = (CNT_W'(DEPTH) - count) >= CNT_W'(FETCH_WIDTH);

    always_comb begin
        push_eff = (CNT_W'(push_cnt) > CNT_W'(FETCH_WIDTH)) ? CNT_W'(FETCH_WIDTH) : CNT_W'(push_cnt);
        pop_req  = (CNT_W'(pop_cnt) > CNT_W'(ISSUE_WIDTH)) ? CNT_W'(ISSUE_WIDTH) : CNT_W'(pop_cnt);
        push_n   = push_ready ? push_eff : '0;
`ifdef INST_QUEUE_BYPASS_EN
        byp      = (count == '0) && !flush;
        avail    = byp ? ((push_n > CNT_W'(ISSUE_WIDTH)) ? CNT_W'(ISSUE_WIDTH) : push_n) : count;
`else
        byp      = 1'b0;
        avail    = count;
`endif
        pops     = (pop_req < avail) ? pop_req : avail;
        // Bypassed-and-consumed slots are never written; head and tail both skip over them.
        skip     = byp ? pops : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PTR_W'(pops);
            tail  <= tail + PTR_W'(push_n);
            count <= count + push_n - pops;
        end
    end

    // Entry payload needs no reset: validity comes from count alone.
    always_ff @(posedge clk) begin
        if (!flush) begin
            for (int unsigned j = 0; j < FETCH_WIDTH; j++) begin
                if (CNT_W'(j) >= skip && CNT_W'(j) < push_n) begin
                    mem_inst[tail + PTR_W'(j)] <= push_inst[j*DATA_WIDTH +: DATA_WIDTH];
                    mem_pc[tail + PTR_W'(j)]   <= push_pc + ADDR_WIDTH'(4*j);
                    mem_exc[tail + PTR_W'(j)]  <= (j == 0) ? push_except : 1'b0;
                    mem_ds[tail + PTR_W'(j)]   <= (j == 0) ? push_delayslot : 1'b0;
                end
            end
        end
    end

    always_comb begin
        out_valid     = '0;
        out_inst      = '0;
        out_pc        = '0;
        out_except    = '0;
        out_delayslot = '0;
        for (int unsigned i = 0; i < ISSUE_WIDTH; i++) begin
            if (CNT_W'(i) < count) begin
                out_valid[i]                        = 1'b1;
                out_inst[i*DATA_WIDTH +: DATA_WIDTH] = mem_inst[head + PTR_W'(i)];
                out_pc[i*ADDR_WIDTH +: ADDR_WIDTH]   = mem_pc[head + PTR_W'(i)];
                out_except[i]                       = mem_exc[head + PTR_W'(i)];
                out_delayslot[i]                    = mem_ds[head + PTR_W'(i)];
            end
        end
`ifdef INST_QUEUE_BYPASS_EN
        if (byp) begin
            for (int unsigned i = 0; i < ISSUE_WIDTH; i++) begin
                if (i < FETCH_WIDTH && CNT_W'(i) < push_n) begin
                    out_valid[i]                        = 1'b1;
                    out_inst[i*DATA_WIDTH +: DATA_WIDTH] = push_inst[i*DATA_WIDTH +: DATA_WIDTH];
                    out_pc[i*ADDR_WIDTH +: ADDR_WIDTH]   = push_pc + ADDR_WIDTH'(4*i);
                    out_except[i]                       = (i == 0) ? push_except : 1'b0;
                    out_delayslot[i]                    = (i == 0) ? push_delayslot : 1'b0;
                end
            end
        end
`endif
    end

`ifdef ASSERT_ON
    pop_within_occupancy: assert property (@(posedge clk) disable iff (!rst)
        !flush |-> (CNT_W'(pop_cnt) <= avail));
`endif

endmodule
